// File: rtl/mips_defs.sv
// Shared definitions for the MIPS execute-stage multiply/divide unit.
// Holds the operation encodings, the FSM state encodings and the default width.
package mips_defs;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/mul_div_datapath.sv
// Magnitude datapath for the multiply/divide unit: operand conditioning,
// one-bit-per-cycle shift-add / restoring shift-subtract, and sign correction.
module mul_div_datapath
  import mips_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             prep,
  input  logic             step,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q;
  logic               neg_r;
  logic               is_div;

  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // op[0] clear selects the signed variants.
  assign sgn_a = ~op[0] & a[WIDTH-1];
  assign sgn_b = ~op[0] & b[WIDTH-1];
  assign abs_a = sgn_a ? -a : a;
  assign abs_b = sgn_b ? -b : b;

  // Multiply: low half holds the remaining multiplier bits, upper half the
  // partial product; the carry of the add shifts in from the top.
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {sum, acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, low half shifts the dividend
  // out and the quotient bits in.
  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, opnd});
  assign new_rem  = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
  assign div_next = {new_rem, acc[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
    end else if (prep) begin
      acc    <= {{WIDTH{1'b0}}, abs_a};
      opnd   <= abs_b;
      neg_q  <= sgn_a ^ sgn_b;
      neg_r  <= sgn_a;
      is_div <= op[1];
    end else if (step) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Start is taken only in IDLE;
// Busy covers PREP..FIX and Done pulses for one cycle as HI/LO take a result.
module mul_div_unit
  import mips_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output state_t           DbgState
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;
  logic             dz;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign dz = op_q[1] && (b_q == '0);

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (Start && !Flush) state_next = S_PREP;
      S_PREP: state_next = Flush ? S_IDLE : (dz ? S_FIX : S_RUN);
      S_RUN:  if (Flush) state_next = S_IDLE;
              else if (cnt == CNT_W'(1)) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (state == S_IDLE && Start && !Flush) begin
        op_q <= Op;
        a_q  <= OperandA;
        b_q  <= OperandB;
      end
      if (state == S_PREP) cnt <= CNT_W'(WIDTH);
      else if (state == S_RUN) cnt <= cnt - 1'b1;
      // A flush in FIX drops the result; MTHI/MTLO only land while idle.
      if (state == S_FIX && !Flush) begin
        hi_q   <= dz ? a_q : res_hi;
        lo_q   <= dz ? {WIDTH{1'b1}} : res_lo;
        done_q <= 1'b1;
        dbz_q  <= dz;
      end else if (state == S_IDLE) begin
        if (WriteHi) hi_q <= WriteData;
        if (WriteLo) lo_q <= WriteData;
      end
    end
  end

  mul_div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (Clk),
    .rst    (Reset),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .prep   (state == S_PREP),
    .step   (state == S_RUN),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign Busy      = (state != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DbgState  = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random stimulus for mul_div_unit with an expected-result queue
// filled at Start and drained at Done.
module tb_mul_div_unit;
  import mips_defs::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic [7:0]   lat;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic         Flush;
  logic         WriteHi;
  logic         WriteLo;
  logic [W-1:0] WriteData;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  state_t       DbgState;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .Flush     (Flush),
    .WriteHi   (WriteHi),
    .WriteLo   (WriteLo),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo),
    .DbgState  (DbgState)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    longint       sa;
    longint       sb;
    longint       q;
    longint       r;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    e.lat = 8'(W + 2);
    case (op)
      OP_MULT: begin
        p = 64'(sa * sb);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          e.dbz = 1'b1;
          e.lat = 8'd2;
          e.hi  = a;
          e.lo  = '1;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // poke_kind: 0 none, 1 extra Start while busy, 2 MTHI while busy.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_kind, input int poke_at);
    exp_t got;
    int   n;
    int   busy_n;
    logic seen;
    exp_q.push_back(model(op, a, b));
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
    n = 0; busy_n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      if (Busy) busy_n++;
      if (poke_kind == 1 && n == poke_at) begin
        Start = 1'b1; Op = OP_MULTU; OperandA = 32'h0000_0003; OperandB = 32'h0000_0005;
      end
      if (poke_kind == 2 && n == poke_at) begin
        WriteHi = 1'b1; WriteData = 32'hdead_beef;
      end
      @(posedge Clk); #1;
      n++;
      Start = 1'b0; WriteHi = 1'b0;
      if (poke_kind == 2 && n == poke_at + 1) check("busy_mthi_hi", 64'(Hi), 64'(hi_m));
      if (Done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    got = exp_q.pop_front();
    if (seen) begin
      check("latency", 64'(n), 64'(got.lat));
      check("busy_cycles", 64'(busy_n), 64'(got.lat));
      check("hi", 64'(Hi), 64'(got.hi));
      check("lo", 64'(Lo), 64'(got.lo));
      check("div_by_zero", 64'(DivByZero), 64'(got.dbz));
      check("busy_after_done", 64'(Busy), 64'd0);
      hi_m = got.hi;
      lo_m = got.lo;
      @(posedge Clk); #1;
      check("done_pulse_width", 64'(Done), 64'd0);
      check("dbz_pulse_width", 64'(DivByZero), 64'd0);
    end
  endtask

  initial begin
    int done_cnt;
    Reset = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
    Flush = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_hi", 64'(Hi), 64'd0);
    check("reset_lo", 64'(Lo), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_dbz", 64'(DivByZero), 64'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 0, 0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_DIVU,  32'd100,       32'd0,         0, 0);
    run_op(OP_DIV,   32'hFFFF_FF9C, 32'd0,         0, 0);
    run_op(OP_DIVU,  32'hFFFF_FFFE, 32'd7,         0, 0);

    // Abort mid-multiply: no result, HI/LO hold.
    Start = 1'b1; Op = OP_MULT; OperandA = 32'd1234; OperandB = 32'd5678;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush_busy", 64'(Busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    check("flush_no_done", 64'(done_cnt), 64'd0);
    check("flush_hi", 64'(Hi), 64'(hi_m));
    check("flush_lo", 64'(Lo), 64'(lo_m));

    // Flush and Start together in IDLE: Start is dropped.
    Start = 1'b1; Flush = 1'b1; Op = OP_MULTU;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("flush_start_busy", 64'(Busy), 64'd0);

    // Start while busy is ignored; the original result comes back.
    run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_0003, 1, 5);

    // MTHI/MTLO in IDLE.
    WriteHi = 1'b1; WriteData = 32'h0000_1234;
    @(posedge Clk); #1;
    WriteHi = 1'b0;
    hi_m = 32'h0000_1234;
    check("mthi_idle", 64'(Hi), 64'(hi_m));
    WriteLo = 1'b1; WriteData = 32'h0000_5678;
    @(posedge Clk); #1;
    WriteLo = 1'b0;
    lo_m = 32'h0000_5678;
    check("mtlo_idle", 64'(Lo), 64'(lo_m));
    check("mtlo_hi_kept", 64'(Hi), 64'(hi_m));

    // MTHI while busy has no effect.
    run_op(OP_DIVU, 32'd1000, 32'd33, 2, 8);

    for (int k = 0; k < 6; k++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      run_op(rop, ra, rb, 0, 0);
    end

    // Asynchronous reset in the middle of RUN.
    Start = 1'b1; Op = OP_MULTU; OperandA = 32'hABCD_0123; OperandB = 32'h0000_0F0F;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(Busy), 64'd0);
    check("async_reset_hi", 64'(Hi), 64'd0);
    check("async_reset_lo", 64'(Lo), 64'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
